// File: rtl/cv32e40p_tmr_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_tmr_pkg : shared types and helpers for the TMR fault controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cv32e40p_tmr_pkg;

  localparam int unsigned TMR_STATS_W = 16;

  typedef enum logic [1:0] {
    TMR_NORMAL = 2'd0,
    TMR_RESYNC = 2'd1,
    TMR_FATAL  = 2'd2
  } tmr_state_e;

  typedef enum logic [2:0] {
    CLS_ALL_EQ   = 3'd0,
    CLS_LONE1    = 3'd1,
    CLS_LONE2    = 3'd2,
    CLS_LONE3    = 3'd3,
    CLS_ALL_DIFF = 3'd4
  } tmr_class_e;

  typedef logic [1:0] tmr_idx_t;

  function automatic tmr_class_e tmr_classify(input logic eq12, input logic eq13,
                                              input logic eq23);
    tmr_class_e cls;
    if (eq12 && eq13)  cls = CLS_ALL_EQ;
    else if (eq12)     cls = CLS_LONE3;
    else if (eq13)     cls = CLS_LONE2;
    else if (eq23)     cls = CLS_LONE1;
    else               cls = CLS_ALL_DIFF;
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40p_tmr_mismatch_cnt.sv
// ----------------------------------------------------------------------------
// cv32e40p_tmr_mismatch_cnt : saturating counter with clear-over-increment priority
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cv32e40p_tmr_mismatch_cnt
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != WIDTH'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// ----------------------------------------------------------------------------
// cv32e40p_tmr_fault_ctrl : TMR voter with replica resync sequencing and fatal escalation.
// Optional per-replica mismatch statistics: define CV32E40P_TMR_STATS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cv32e40p_tmr_fault_ctrl
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned THRESH         = 4,
  parameter int unsigned RESYNC_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [WIDTH-1:0]              res1_i,
  input  logic [WIDTH-1:0]              res2_i,
  input  logic [WIDTH-1:0]              res3_i,
  input  logic                          clr_i,
  output logic [WIDTH-1:0]              result_o,
  output logic                          result_valid_o,
  output logic [1:0]                    faulty_idx_o,
  output logic                          resync_req_o,
  input  logic                          resync_ack_i,
  output logic                          fatal_o,
  output logic [3:1][TMR_STATS_W-1:0]   mm_cnt_o
);

  localparam int unsigned CNT_W = $clog2(THRESH + 1);
  localparam int unsigned TMR_W = $clog2(RESYNC_TIMEOUT + 1);

  tmr_state_e             state_q, state_d;
  tmr_idx_t               idx_q, idx_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [WIDTH-1:0]       result_q, w_vote;
  logic                   rvalid_q;
  tmr_class_e             w_cls;
  logic                   w_all_eq, w_all_diff, w_lone_any, w_norm, w_ack, w_second;
  logic [3:1]             w_lone, w_hit, w_idx_oh, w_cnt_inc, w_cnt_clr;
  logic [3:1][CNT_W-1:0]  w_cnt;

  assign w_cls      = tmr_classify(res1_i == res2_i, res1_i == res3_i, res2_i == res3_i);
  assign w_vote     = ((res1_i == res2_i) || (res1_i == res3_i)) ? res1_i : res2_i;
  assign w_all_eq   = valid_i && (w_cls == CLS_ALL_EQ);
  assign w_all_diff = valid_i && (w_cls == CLS_ALL_DIFF);
  assign w_lone     = {3{valid_i}} & {w_cls == CLS_LONE3, w_cls == CLS_LONE2, w_cls == CLS_LONE1};
  assign w_lone_any = |w_lone;
  assign w_norm     = (state_q == TMR_NORMAL) && !clr_i;
  assign w_ack      = (state_q == TMR_RESYNC) && resync_ack_i;
  assign w_idx_oh   = {idx_q == 2'd3, idx_q == 2'd2, idx_q == 2'd1};
  // Any disagreement not attributable to the replica already under resync.
  assign w_second   = w_all_diff || (|(w_lone & ~w_idx_oh));

  for (genvar k = 1; k <= 3; k++) begin : g_consec
    assign w_cnt_inc[k] = w_norm && w_lone[k];
    assign w_cnt_clr[k] = clr_i || w_ack ||
                          (w_norm && (w_all_eq || (w_lone_any && !w_lone[k])));
    assign w_hit[k]     = w_cnt_inc[k] && (w_cnt[k] == CNT_W'(THRESH - 1));

    cv32e40p_tmr_mismatch_cnt #(
      .WIDTH (CNT_W),
      .MAX   (THRESH)
    ) u_consec_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (w_cnt_clr[k]),
      .inc_i (w_cnt_inc[k]),
      .cnt_o (w_cnt[k])
    );
  end

`ifdef CV32E40P_TMR_STATS_EN
  for (genvar k = 1; k <= 3; k++) begin : g_stats
    logic w_inc;
    // On ALL_DIFF the vote follows replica 2, so replicas 1 and 3 disagree.
    assign w_inc = w_lone[k] || (w_all_diff && (k != 2));

    cv32e40p_tmr_mismatch_cnt #(
      .WIDTH (TMR_STATS_W),
      .MAX   ((1 << TMR_STATS_W) - 1)
    ) u_stats_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (1'b0),
      .inc_i (w_inc),
      .cnt_o (mm_cnt_o[k])
    );
  end
`else
  assign mm_cnt_o = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TMR_NORMAL;
      idx_q    <= '0;
      timer_q  <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      rvalid_q <= valid_i;
      if (valid_i) result_q <= w_vote;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    case (state_q)
      TMR_NORMAL: begin
        timer_d = '0;
        if (w_all_diff) begin
          state_d = TMR_FATAL;
        end else if (|w_hit) begin
          state_d = TMR_RESYNC;
          idx_d   = w_hit[1] ? 2'd1 : (w_hit[2] ? 2'd2 : 2'd3);
        end
      end
      TMR_RESYNC: begin
        if (resync_ack_i) begin
          state_d = TMR_NORMAL;
          idx_d   = '0;
          timer_d = '0;
        end else if (w_second || (timer_q == TMR_W'(RESYNC_TIMEOUT - 1))) begin
          state_d = TMR_FATAL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TMR_FATAL: begin
        state_d = TMR_FATAL;
      end
      default: begin
        state_d = TMR_NORMAL;
      end
    endcase
    if (clr_i) begin
      state_d = TMR_NORMAL;
      idx_d   = '0;
      timer_d = '0;
    end
  end

  always_comb begin
    result_o       = result_q;
    result_valid_o = rvalid_q && (state_q != TMR_FATAL);
    faulty_idx_o   = idx_q;
    resync_req_o   = (state_q == TMR_RESYNC);
    fatal_o        = (state_q == TMR_FATAL);
  end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_tmr_fault_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_tmr_fault_ctrl : scoreboard bench with directed scenarios and random traffic.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40p_tmr_fault_ctrl;

  localparam int WIDTH  = 32;
  localparam int THRESH = 4;
  localparam int TO     = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_i, clr_i, resync_ack_i;
  logic [WIDTH-1:0]     res1_i, res2_i, res3_i;
  logic [WIDTH-1:0]     result_o;
  logic                 result_valid_o, resync_req_o, fatal_o;
  logic [1:0]           faulty_idx_o;
  logic [3:1][15:0]     mm_cnt_o;

  cv32e40p_tmr_fault_ctrl #(
    .WIDTH(WIDTH), .THRESH(THRESH), .RESYNC_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .res1_i(res1_i), .res2_i(res2_i),
    .res3_i(res3_i), .clr_i(clr_i), .result_o(result_o), .result_valid_o(result_valid_o),
    .faulty_idx_o(faulty_idx_o), .resync_req_o(resync_req_o), .resync_ack_i(resync_ack_i),
    .fatal_o(fatal_o), .mm_cnt_o(mm_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=normal 1=resync 2=fatal
  int m_mode, m_idx, m_timer;
  int m_c[1:3];
  int m_stats[1:3];
  logic [WIDTH-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_timer = 0;
    for (int k = 1; k <= 3; k++) begin m_c[k] = 0; m_stats[k] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [WIDTH-1:0] a, b, c,
                            input bit ack, input bit clr);
    bit all_eq, all_diff;
    int odd;
    logic [WIDTH-1:0] voted;
    all_eq = (a == b) && (b == c);
    odd = 0;
    if (!all_eq) begin
      if (b == c) odd = 1;
      else if (a == c) odd = 2;
      else if (a == b) odd = 3;
    end
    all_diff = !all_eq && (odd == 0);
    voted = ((a == b) || (a == c)) ? a : b;
    if (v) begin
      if (odd != 0 && m_stats[odd] < 65535) m_stats[odd]++;
      if (all_diff) begin
        if (m_stats[1] < 65535) m_stats[1]++;
        if (m_stats[3] < 65535) m_stats[3]++;
      end
    end
    if (clr) begin
      m_mode = 0; m_idx = 0; m_timer = 0;
      for (int k = 1; k <= 3; k++) m_c[k] = 0;
    end else if (m_mode == 0) begin
      if (v && all_diff) m_mode = 2;
      else if (v && all_eq) for (int k = 1; k <= 3; k++) m_c[k] = 0;
      else if (v && odd != 0) begin
        for (int k = 1; k <= 3; k++)
          m_c[k] = (k == odd) ? ((m_c[k] < THRESH) ? m_c[k] + 1 : THRESH) : 0;
        if (m_c[odd] == THRESH) begin m_mode = 1; m_idx = odd; m_timer = 0; end
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        m_mode = 0; m_idx = 0; m_timer = 0;
        for (int k = 1; k <= 3; k++) m_c[k] = 0;
      end else if (v && (all_diff || (odd != 0 && odd != m_idx))) m_mode = 2;
      else if (m_timer + 1 == TO) m_mode = 2;
      else m_timer++;
    end
    if (v && m_mode != 2) exp_q.push_back(voted);
  endtask

  task automatic check_status();
    logic [1:0] ei;
    logic [3:1][15:0] emm;
    ei = m_idx[1:0];
    emm = '0;
`ifdef CV32E40P_TMR_STATS_EN
    for (int k = 1; k <= 3; k++) emm[k] = m_stats[k][15:0];
`endif
    checks++;
    if ({fatal_o, resync_req_o, faulty_idx_o} !== {m_mode == 2, m_mode == 1, ei}) begin
      errors++;
      $display("FAIL status @%0t: fatal/req/idx got %b/%b/%0d want %b/%b/%0d", $time,
               fatal_o, resync_req_o, faulty_idx_o, m_mode == 2, m_mode == 1, ei);
    end
    checks++;
    if (mm_cnt_o !== emm) begin
      errors++;
      $display("FAIL mm_cnt @%0t: got %h want %h", $time, mm_cnt_o, emm);
    end
  endtask

  // Called at a negedge, returns at the following negedge.
  task automatic step(input bit v, input logic [WIDTH-1:0] a, b, c,
                      input bit ack, input bit clr);
    valid_i = v; res1_i = a; res2_i = b; res3_i = c; resync_ack_i = ack; clr_i = clr;
    model_step(v, a, b, c, ack, clr);
    @(posedge clk); #1;
    check_status();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ack, 1'b0);
  endtask

  task automatic mk(input int kind, output logic [WIDTH-1:0] a, b, c);
    logic [WIDTH-1:0] x, y;
    x = $urandom;
    y = x ^ (32'd1 << $urandom_range(31, 0));
    a = x; b = x; c = x;
    case (kind)
      1: a = y;
      2: b = y;
      3: c = y;
      4: begin b = y; c = ~x; end
      default: ;
    endcase
  endtask

  task automatic beat(input int kind, input bit ack, input bit clr);
    logic [WIDTH-1:0] a, b, c;
    mk(kind, a, b, c);
    step(1'b1, a, b, c, ack, clr);
  endtask

  task automatic beats(input int kind, input int n);
    for (int i = 0; i < n; i++) beat(kind, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; clr_i = 1'b0; resync_ack_i = 1'b0;
    #1;
    checks++;
    if ({result_o, result_valid_o, faulty_idx_o, resync_req_o, fatal_o} !== '0 ||
        mm_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset: res=%h v=%b idx=%0d req=%b fatal=%b mm=%h want all zero",
               result_o, result_valid_o, faulty_idx_o, resync_req_o, fatal_o, mm_cnt_o);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Result scoreboard monitor
  always @(posedge clk) begin
    logic [WIDTH-1:0] e;
    #1;
    if (!rst) begin
      if (result_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_valid @%0t: spurious output %h", $time, result_o);
        end else begin
          e = exp_q.pop_front();
          if (result_o !== e) begin
            errors++;
            $display("FAIL result @%0t: got %h want %h", $time, result_o, e);
          end
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL result_valid @%0t: missing output, want %h", $time, exp_q[0]);
        exp_q.delete();
      end
    end
  end

  initial begin
    int guard, fav;
    bit v, ack, clr;
    int p, kind;
    valid_i = 0; clr_i = 0; resync_ack_i = 0;
    res1_i = '0; res2_i = '0; res3_i = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // All replicas equal
    for (int i = 0; i < 10; i++) step(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);

    // Replica 2 faulty, acked after 5 cycles; then sub-threshold run
    beats(2, 4);
    idle(4, 1'b0);
    idle(1, 1'b1);
    beats(2, 3);
    beats(0, 1);
    idle(2, 1'b0);

    // Resync timeout, beat while fatal, clear with a beat
    beats(2, 4);
    idle(66, 1'b0);
    beats(0, 1);
    beat(0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // ALL_DIFF escalation
    step(1'b1, 32'd1, 32'd2, 32'd3, 0, 0);
    checks++;
    if (result_o !== 32'd2) begin
      errors++;
      $display("FAIL all_diff_vote: got %h want %h", result_o, 32'd2);
    end
    idle(1, 1'b0);
    step(1'b0, '0, '0, '0, 0, 1);
    // Second fault during resync
    beats(2, 4);
    beats(3, 1);
    idle(1, 1'b0);
    step(1'b0, '0, '0, '0, 0, 1);

    // Ack on the timeout cycle, then clr with ALL_DIFF
    beats(2, 4);
    guard = 0;
    while (m_mode == 1 && m_timer < TO - 1 && guard < 200) begin idle(1, 1'b0); guard++; end
    idle(1, 1'b1);
    step(1'b1, 32'd1, 32'd2, 32'd3, 0, 1);
    idle(2, 1'b0);

    // Reset during resync
    beats(2, 4);
    idle(3, 1'b0);
    do_reset();
    idle(2, 1'b0);

`ifdef CV32E40P_TMR_STATS_EN
    for (int i = 0; i < 70000; i++) beat(1, 1'b1, 1'b0);
    idle(2, 1'b0);
`endif

    // Random traffic
    fav = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) fav = $urandom_range(3, 1);
      v = ($urandom_range(9, 0) < 8);
      p = $urandom_range(99, 0);
      if (p < 35) kind = 0;
      else if (p < 85) kind = fav;
      else if (p < 98) kind = $urandom_range(3, 1);
      else kind = 4;
      ack = (m_mode == 1) ? ($urandom_range(29, 0) == 0) : ($urandom_range(49, 0) == 0);
      clr = (m_mode == 2) ? ($urandom_range(7, 0) == 0) : ($urandom_range(199, 0) == 0);
      if (v) beat(kind, ack, clr);
      else step(1'b0, $urandom, $urandom, $urandom, ack, clr);
    end
    idle(3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
